// File: rtl/sr_imem_loader_pkg.sv
// rtl/sr_imem_loader_pkg.sv - shared state encodings, frame constants and count check for the imem loader
package sr_imem_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = WORD_W / BYTE_W;
    localparam int IDX_W      = $clog2(WORD_BYTES);
    localparam int CNT_W      = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CNT_LO = 3'd1;
    localparam state_t ST_CNT_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_CHK    = 3'd5;
    localparam state_t ST_DONE   = 3'd6;
    localparam state_t ST_ERR    = 3'd7;

    // A word count is loadable when it is non-zero and fits in 2^addr_w words.
    function automatic logic count_ok(input logic [CNT_W-1:0] n, input int unsigned addr_w);
        logic [CNT_W:0] cap;
        if (addr_w >= CNT_W) begin
            return n != '0;
        end
        cap = (CNT_W + 1)'(1) << addr_w;
        return (n != '0) && ({1'b0, n} <= cap);
    endfunction

endpackage

// File: rtl/sr_imem_loader_if.sv
// rtl/sr_imem_loader_if.sv - valid/ready byte stream into the imem loader
interface sr_imem_loader_if;
    import sr_imem_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    // Byte source side (UART RX, bench driver).
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Loader side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/sr_imem_loader_wordasm.sv
// rtl/sr_imem_loader_wordasm.sv - little-endian word assembler with running XOR checksum
module sr_imem_loader_wordasm
    import sr_imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] chk,
    output logic              last
);

    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic [BYTE_W-1:0] chk_q;
    logic [BYTE_W-1:0] chk_d;

    // Drop each accepted byte into its lane and fold it into the checksum.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        chk_d  = chk_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
            chk_d  = '0;
        end else if (accept) begin
            word_d[{idx_q, 3'b000} +: BYTE_W] = in_byte;
            chk_d = chk_q ^ in_byte;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Assembly state; the byte index wraps naturally after the last lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
            chk_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            chk_q  <= chk_d;
        end
    end

    assign word = word_q;
    assign chk  = chk_q;
    assign last = accept && !clear && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/sr_imem_loader.sv
// rtl/sr_imem_loader.sv - framed byte-stream loader for schoolRISCV instruction memory
module sr_imem_loader
    import sr_imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    sr_imem_loader_if.slave   s_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Idle counter wide enough to reach TIMEOUT; a 1-bit stub when disabled.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  rem_d;
    logic [BYTE_W-1:0] cnt_lo_q;
    logic [BYTE_W-1:0] cnt_lo_d;
    logic [TW-1:0]     idle_q;
    logic [TW-1:0]     idle_d;
    logic              cpu_rst_n_q;
    logic              cpu_rst_n_d;
    logic              done_q;
    logic              done_d;
    logic              error_q;
    logic              error_d;

    logic              in_ready;
    logic              xfer;
    logic              asm_clear;
    logic              asm_accept;
    logic              asm_last;
    logic [WORD_W-1:0] asm_word;
    logic [BYTE_W-1:0] asm_chk;
    logic [CNT_W-1:0]  n_word;

    // Only the byte-consuming states open the stream.
    always_comb begin
        in_ready = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                   (state_q == ST_DATA)   || (state_q == ST_CHK);
    end

    assign s_in.in_ready = in_ready;
    assign xfer          = s_in.in_valid && in_ready;
    assign asm_accept    = xfer && (state_q == ST_DATA);
    assign n_word        = {s_in.in_data, cnt_lo_q};

    sr_imem_loader_wordasm u_wordasm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (asm_clear),
        .accept  (asm_accept),
        .in_byte (s_in.in_data),
        .word    (asm_word),
        .chk     (asm_chk),
        .last    (asm_last)
    );

    // Frame sequencing, address/count bookkeeping and the inter-byte watchdog.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cnt_lo_d    = cnt_lo_q;
        idle_d      = '0;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
        error_d     = error_q;
        asm_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_CNT_LO;
                    addr_d      = '0;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    asm_clear   = 1'b1;
                end
            end
            ST_CNT_LO: begin
                if (xfer) begin
                    cnt_lo_d = s_in.in_data;
                    state_d  = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (xfer) begin
                    if (count_ok(n_word, ADDR_W)) begin
                        rem_d   = n_word;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (asm_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A full-capacity load leaves the address wrapped to 0, harmlessly.
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                if (xfer) begin
                    if (s_in.in_data == asm_chk) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A stalled source inside a frame aborts it; any transfer rearms the count.
        if (in_ready && !xfer) begin
            idle_d = idle_q + TW'(1);
            if ((TIMEOUT != 0) && (32'(idle_d) == TIMEOUT)) begin
                state_d = ST_ERR;
                error_d = 1'b1;
            end
        end
    end

    // Loader registers; reset leaves the CPU held and the loader idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            cnt_lo_q    <= '0;
            idle_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cnt_lo_q    <= cnt_lo_d;
            idle_q      <= idle_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = asm_word;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: doc/sr_imem_loader.md
Name: sr_imem_loader

Overview:
- Byte-stream program loader for the schoolRISCV instruction memory.
- Accepts a framed little-endian byte stream over a valid/ready interface, assembles 32-bit RV32 instruction words and writes them to consecutive imem word addresses.
- Holds the CPU in reset while loading and releases it only after a checksummed frame completes.
- Sits between a host byte source (UART RX or bench driver) and the imem write port / sm_cpu reset.

Parameters:
- ADDR_W, 6, imem word-address width; capacity is 2^ADDR_W words.
- TIMEOUT, 1000000, maximum idle cycles between bytes inside a frame before aborting. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a new load (ignored in CNT_LO..WRITE).
- in_valid  in  1  byte available.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle.
- imem_we  out  1  single-cycle word write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  instruction word.
- cpu_rst_n  out  1  active-low reset to sm_cpu.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded successfully (sticky until next start).
- error  out  1  last frame aborted (sticky until next start).

Behaviour:
- Frame format: CNT_LO, CNT_HI (word count N, 16-bit LE), then N words of 4 bytes each (LE, byte0 = instr[7:0]), then CHK.
- CHK is the XOR of all 4N data bytes; count bytes are excluded.
- Handshake: a byte transfers on cycles where in_valid && in_ready. in_data is sampled only on transfer.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0. State is IDLE.
- States and transitions:
  - IDLE: in_ready=0. start -> CNT_LO; clears done/error, imem_addr=0, chk=0, cpu_rst_n=0.
  - CNT_LO: in_ready=1; on transfer -> CNT_HI.
  - CNT_HI: in_ready=1; on transfer evaluate N. N==0 or N>2^ADDR_W -> ERR. Otherwise -> DATA with byte index 0.
  - DATA: in_ready=1; shift the byte into position [8*idx +: 8] and XOR it into chk. On the 4th byte -> WRITE.
  - WRITE: in_ready=0. imem_we=1 for exactly one cycle with the assembled word at imem_addr. Then increment imem_addr and decrement the remaining count. Remaining==0 -> CHK, else -> DATA.
  - CHK: in_ready=1; on transfer, byte==chk -> DONE, else -> ERR.
  - DONE: done=1, cpu_rst_n=1 from the cycle after the CHK transfer, then IDLE.
  - ERR: error=1, cpu_rst_n stays 0, then IDLE.
- Latency: imem_we rises exactly 1 cycle after the 4th byte of a word transfers. Minimum 5 cycles per word.
- busy=1 in every state except IDLE.
- cpu_rst_n stays 1 while idle after a successful load. It falls in the cycle after start.
- Timeout: the idle counter increments each cycle in CNT_LO/CNT_HI/DATA/CHK without a transfer and resets on each transfer. Reaching TIMEOUT -> ERR.
- N == 2^ADDR_W: the last write hits address 2^ADDR_W-1. The address wraps to 0 internally but no further write occurs.
- start asserted while busy is ignored. An in_valid byte while in IDLE or WRITE is not consumed.
- rst_n asserted mid-frame: immediate return to reset values. A partially written imem is not cleared.

Decomposition:
- Shared package/header (sr_loader.vh): state encodings (IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHK, DONE, ERR) and the frame-field constants.
- One natural sub-module, sr_loader_wordasm: byte-index counter, 32-bit shift/assemble register and XOR checksum accumulator, with clear and byte-accept inputs.
- The FSM, address/count and timeout counters live in the top.

Test Plan:
- N=1, bytes 13 05 A0 00 (addi a0,x0,10 = 0x00A00513), CHK=0xB6 -> one imem_we, addr 0, wdata 0x00A00513; done=1, cpu_rst_n=1, error=0.
- N=3 with in_valid randomly deasserted 50% of cycles -> three writes at addrs 0,1,2 with the correct words; in_ready=0 during each WRITE cycle; done=1.
- N=1, correct data but CHK=0x00 -> imem_we pulses once, error=1, cpu_rst_n stays 0, done=0.
- N=0, then separately N=65 with ADDR_W=6 -> ERR immediately after CNT_HI, no imem_we, error=1.
- TIMEOUT=16, stream stops after 2 data bytes -> error=1 exactly 16 cycles after the last transfer; a subsequent start plus a valid frame -> done=1.
- rst_n pulsed low mid-DATA, then start with a full N=2 frame -> all outputs at reset values during reset; load completes with writes at addrs 0,1.
